// File: rtl/jpeg_block_to_raster_pkg.sv
`default_nettype none
// =============================================================================
// jpeg_block_to_raster_pkg: shared constants and FSM encodings for the reorder buffer
// Rev 1.0
// =============================================================================
package jpeg_block_to_raster_pkg;

    localparam int BLK_DIM   = 8;
    localparam int BLK_SHIFT = 3;
    localparam int RGB_W     = 24;

    typedef enum logic [0:0] {
        W_IDLE = 1'b0,
        W_FILL = 1'b1
    } wr_state_t;

    typedef enum logic [0:0] {
        R_IDLE  = 1'b0,
        R_DRAIN = 1'b1
    } rd_state_t;

endpackage : jpeg_block_to_raster_pkg
`default_nettype wire

// File: rtl/jpeg_block_to_raster_band_ram.sv
`default_nettype none
// =============================================================================
// jpeg_block_to_raster_band_ram: 1W1R synchronous band memory, 1-cycle read latency
// Rev 1.0
// =============================================================================
module jpeg_block_to_raster_band_ram
    import jpeg_block_to_raster_pkg::*;
#(
    parameter int DEPTH = 8192,
    parameter int AW    = 13,
    parameter int DW    = RGB_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read register only updates on re, so it doubles as the stall-hold data stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule : jpeg_block_to_raster_band_ram
`default_nettype wire

// File: rtl/jpeg_block_to_raster.sv
`default_nettype none
// =============================================================================
// jpeg_block_to_raster: re-orders 8x8-block pixels into cropped raster order via ping-pong bands
// Rev 1.0
// =============================================================================
module jpeg_block_to_raster
    import jpeg_block_to_raster_pkg::*;
#(
    parameter int MAX_WIDTH = 1024,
    parameter int DIM_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_start,
    input  logic [DIM_W-1:0] img_width,
    input  logic [DIM_W-1:0] img_height,
    input  logic [7:0]       r_in,
    input  logic [7:0]       g_in,
    input  logic [7:0]       b_in,
    input  logic             rgb_in_valid,
    output logic [7:0]       r_out,
    output logic [7:0]       g_out,
    output logic [7:0]       b_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             sof,
    output logic             eol,
    output logic             eof,
    output logic             overflow,
    output logic             dim_err
);

    localparam int DEPTH = BLK_DIM * MAX_WIDTH;
    localparam int AW    = $clog2(DEPTH);
    localparam int BW    = DIM_W + 1 - BLK_SHIFT;

    // Frame geometry
    logic [DIM_W-1:0] width_q, height_q;
    logic [BW-1:0]    blk_last, band_last;
    logic             dims_ok;
    logic [BW-1:0]    blks_m1_in, bands_m1_in;

    // Writer
    wr_state_t        w_state, w_next;
    logic             wbank;
    logic [2:0]       col, row;
    logic [BW-1:0]    blk, band;
    logic             pix_ok, wr_en, pix_drop, band_done, frame_done;
    logic [AW-1:0]    wr_addr;

    // Reader
    rd_state_t        r_state, r_next;
    logic             rbank, rsel;
    logic [DIM_W-1:0] x, ry;
    logic             advance, rd_go, x_last, row_last, band_end, frame_end;
    logic [AW-1:0]    rd_addr;

    logic [1:0]       bank_full, bank_set, bank_clr;
    logic [RGB_W-1:0] rd_data [2];

    assign dims_ok     = (img_width != '0) && (img_height != '0)
                       && (32'(img_width) <= 32'(MAX_WIDTH));
    assign blks_m1_in  = BW'(((32'(img_width)  + 32'd7) >> BLK_SHIFT) - 32'd1);
    assign bands_m1_in = BW'(((32'(img_height) + 32'd7) >> BLK_SHIFT) - 32'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            width_q   <= '0;
            height_q  <= '0;
            blk_last  <= '0;
            band_last <= '0;
            dim_err   <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (frame_start) begin
                width_q   <= img_width;
                height_q  <= img_height;
                blk_last  <= blks_m1_in;
                band_last <= bands_m1_in;
                if (!dims_ok) begin
                    dim_err <= 1'b1;
                end
            end
            if (pix_drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // ---------------- Writer FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state <= W_IDLE;
        end else begin
            w_state <= w_next;
        end
    end

    always_comb begin
        w_next = w_state;
        if (frame_start) begin
            w_next = dims_ok ? W_FILL : W_IDLE;
        end else if (frame_done) begin
            w_next = W_IDLE;
        end
    end

    always_comb begin
        pix_ok     = (w_state == W_FILL) && rgb_in_valid && !frame_start;
        wr_en      = pix_ok && !bank_full[wbank];
        pix_drop   = pix_ok && bank_full[wbank];
        band_done  = wr_en && (&col) && (&row) && (blk == blk_last);
        frame_done = band_done && (band == band_last);
        wr_addr    = AW'(row) * AW'(MAX_WIDTH) + AW'({blk, col});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbank <= 1'b0;
            col   <= '0;
            row   <= '0;
            blk   <= '0;
            band  <= '0;
        end else if (frame_start) begin
            wbank <= 1'b0;
            col   <= '0;
            row   <= '0;
            blk   <= '0;
            band  <= '0;
        end else if (wr_en) begin
            col <= col + 3'd1;
            if (&col) begin
                row <= row + 3'd1;
                if (&row) begin
                    if (blk == blk_last) begin
                        blk   <= '0;
                        band  <= band + BW'(1);
                        wbank <= ~wbank;
                    end else begin
                        blk <= blk + BW'(1);
                    end
                end
            end
        end
    end

    // ---------------- Bank flags ----------------
    // Set and clear always target different banks, so both may land in one cycle.
    assign bank_set = band_done           ? (wbank ? 2'b10 : 2'b01) : 2'b00;
    assign bank_clr = (rd_go && band_end) ? (rbank ? 2'b10 : 2'b01) : 2'b00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_full <= 2'b00;
        end else if (frame_start) begin
            bank_full <= 2'b00;
        end else begin
            bank_full <= (bank_full & ~bank_clr) | bank_set;
        end
    end

    // ---------------- Reader FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= R_IDLE;
        end else begin
            r_state <= r_next;
        end
    end

    always_comb begin
        r_next = r_state;
        if (frame_start) begin
            r_next = R_IDLE;
        end else if (rd_go) begin
            r_next = band_end ? R_IDLE : R_DRAIN;
        end
    end

    always_comb begin
        advance   = !out_valid || out_ready;
        rd_go     = bank_full[rbank] && advance && !frame_start;
        x_last    = (x == width_q - DIM_W'(1));
        row_last  = (ry == height_q - DIM_W'(1));
        band_end  = x_last && ((&ry[BLK_SHIFT-1:0]) || row_last);
        frame_end = x_last && row_last;
        rd_addr   = AW'(ry[BLK_SHIFT-1:0]) * AW'(MAX_WIDTH) + AW'(x);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rbank     <= 1'b0;
            rsel      <= 1'b0;
            x         <= '0;
            ry        <= '0;
            out_valid <= 1'b0;
            sof       <= 1'b0;
            eol       <= 1'b0;
            eof       <= 1'b0;
        end else if (frame_start) begin
            rbank     <= 1'b0;
            rsel      <= 1'b0;
            x         <= '0;
            ry        <= '0;
            out_valid <= 1'b0;
            sof       <= 1'b0;
            eol       <= 1'b0;
            eof       <= 1'b0;
        end else begin
            if (advance) begin
                out_valid <= rd_go;
                sof       <= rd_go && (x == '0) && (ry == '0);
                eol       <= rd_go && x_last;
                eof       <= rd_go && frame_end;
            end
            if (rd_go) begin
                rsel <= rbank;
                if (x_last) begin
                    x  <= '0;
                    ry <= row_last ? '0 : ry + DIM_W'(1);
                end else begin
                    x <= x + DIM_W'(1);
                end
                if (band_end) begin
                    rbank <= ~rbank;
                end
            end
        end
    end

    // ---------------- Band memories ----------------
    for (genvar b = 0; b < 2; b++) begin : g_bank
        jpeg_block_to_raster_band_ram #(
            .DEPTH (DEPTH),
            .AW    (AW),
            .DW    (RGB_W)
        ) u_ram (
            .clk   (clk),
            .rst_n (rst_n),
            .we    (wr_en && (wbank == 1'(b))),
            .waddr (wr_addr),
            .wdata ({r_in, g_in, b_in}),
            .re    (rd_go && (rbank == 1'(b))),
            .raddr (rd_addr),
            .rdata (rd_data[b])
        );
    end

    assign {r_out, g_out, b_out} = rd_data[rsel];

endmodule : jpeg_block_to_raster
`default_nettype wire
